// File: rtl/spi_display_rx.sv
// SPI mode-0 slave front end for the display register file: oversamples SCLK/SS/MOSI,
// assembles (address, data) byte pairs into write strobes and echoes accepted bytes on MISO.
module spi_display_rx #(
   parameter int unsigned SYNC_STAGES  = 2,
   parameter int unsigned PAIR_TIMEOUT = 1023
) (
   input  logic       block_clk_i,
   input  logic       rst_i,
   input  logic       spi_sclk_i,
   input  logic       spi_ss_i,
   input  logic       spi_mosi_i,
   output logic       spi_miso_o,
   output logic       wr_en_o,
   output logic [7:0] wr_addr_o,
   output logic [7:0] wr_data_o,
   output logic       frame_err_o,
   output logic       busy_o
);

   localparam int unsigned TW = (PAIR_TIMEOUT < 2) ? 1 : $clog2(PAIR_TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(PAIR_TIMEOUT);

   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

   state_t                 state, state_n;
   logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
   logic                   sclk_d, ss_d;
   logic                   sclk_s, ss_s, mosi_s;
   logic                   sclk_rise, sclk_fall, ss_rise, ss_fall;
   logic [7:0]             shift, tx, tx_next, echo, pend_addr;
   logic [2:0]             bit_cnt;
   logic                   byte_valid;
   logic [TW-1:0]          timer;
   logic                   timeout;
   logic                   wr_en_n, err_n, take_addr, take_data, drop_addr;

   assign sclk_s    = sclk_sync[SYNC_STAGES-1];
   assign ss_s      = ss_sync[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync[SYNC_STAGES-1];
   assign sclk_rise = sclk_s & ~sclk_d;
   assign sclk_fall = ~sclk_s & sclk_d;
   assign ss_rise   = ss_s & ~ss_d;
   assign ss_fall   = ~ss_s & ss_d;
   assign busy_o    = ~ss_s;
   assign timeout   = (timer == TIMEOUT_LAST);

   // On the SS-fall cycle tx is not yet loaded, so bypass straight from echo.
   assign spi_miso_o = ss_s ? 1'b0 : (ss_d ? echo[7] : tx[7]);

   always_ff @(posedge block_clk_i or posedge rst_i) begin
      if (rst_i) begin
         sclk_sync <= '0;
         ss_sync   <= '1;
         mosi_sync <= '0;
         sclk_d    <= 1'b0;
         ss_d      <= 1'b1;
      end else begin
         sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], spi_sclk_i};
         ss_sync   <= {ss_sync[SYNC_STAGES-2:0], spi_ss_i};
         mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi_i};
         sclk_d    <= sclk_s;
         ss_d      <= ss_s;
      end
   end

   // tx_next snapshots echo at the last capture of a byte, before that byte is accepted,
   // and is swapped into tx on the trailing falling edge (bit counter already wrapped).
   always_ff @(posedge block_clk_i or posedge rst_i) begin
      if (rst_i) begin
         shift      <= '0;
         bit_cnt    <= '0;
         byte_valid <= 1'b0;
         tx         <= '0;
         tx_next    <= '0;
      end else begin
         byte_valid <= 1'b0;
         if (ss_rise) begin
            bit_cnt <= '0;
            shift   <= '0;
         end else if (sclk_rise && !ss_s) begin
            shift   <= {shift[6:0], mosi_s};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
               byte_valid <= 1'b1;
               tx_next    <= echo;
            end
         end
         if (ss_fall) begin
            tx <= echo;
         end else if (sclk_fall && !ss_s) begin
            tx <= (bit_cnt == 3'd0) ? tx_next : {tx[6:0], 1'b0};
         end
      end
   end

   always_comb begin
      state_n   = state;
      wr_en_n   = 1'b0;
      err_n     = 1'b0;
      take_addr = 1'b0;
      take_data = 1'b0;
      drop_addr = 1'b0;
      if (ss_rise) begin
         state_n = IDLE;
         err_n   = (bit_cnt != 3'd0) || (state == DATA) || byte_valid;
      end else begin
         case (state)
            IDLE: if (ss_fall) state_n = ADDR;
            ADDR: if (byte_valid) begin
               take_addr = 1'b1;
               state_n   = DATA;
            end
            DATA: if (byte_valid) begin
               take_data = 1'b1;
               wr_en_n   = 1'b1;
               state_n   = ADDR;
            end else if (timeout) begin
               err_n     = 1'b1;
               drop_addr = 1'b1;
               state_n   = ADDR;
            end
            default: state_n = IDLE;
         endcase
      end
   end

   always_ff @(posedge block_clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= IDLE;
         wr_en_o     <= 1'b0;
         frame_err_o <= 1'b0;
         wr_addr_o   <= '0;
         wr_data_o   <= '0;
         pend_addr   <= '0;
         echo        <= '0;
         timer       <= '0;
      end else begin
         state       <= state_n;
         wr_en_o     <= wr_en_n;
         frame_err_o <= err_n;
         timer       <= (state == DATA && state_n == DATA) ? timer + TW'(1) : '0;
         if (take_addr) begin
            pend_addr <= shift;
            echo      <= shift;
         end
         if (take_data) begin
            wr_addr_o <= pend_addr;
            wr_data_o <= shift;
            echo      <= shift;
         end
         if (drop_addr) pend_addr <= '0;
      end
   end

endmodule

// File: tb/tb_spi_display_rx.sv
// Directed bench for spi_display_rx: drives SPI frames at block_clk/4 and checks strobes,
// frame errors and the MISO echo against hand-computed values.
module tb_spi_display_rx;

   localparam int unsigned TIMEOUT = 1023;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       sclk = 1'b0;
   logic       ss   = 1'b1;
   logic       mosi = 1'b0;
   logic       miso, wr_en, err, busy;
   logic [7:0] wr_addr, wr_data;

   int         checks   = 0;
   int         failures = 0;
   int         wr_cnt   = 0;
   int         err_cnt  = 0;
   logic [7:0] log_addr [16];
   logic [7:0] log_data [16];

   always #5 clk = ~clk;

   spi_display_rx #(
      .SYNC_STAGES (2),
      .PAIR_TIMEOUT(TIMEOUT)
   ) dut (
      .block_clk_i(clk),
      .rst_i      (rst),
      .spi_sclk_i (sclk),
      .spi_ss_i   (ss),
      .spi_mosi_i (mosi),
      .spi_miso_o (miso),
      .wr_en_o    (wr_en),
      .wr_addr_o  (wr_addr),
      .wr_data_o  (wr_data),
      .frame_err_o(err),
      .busy_o     (busy)
   );

   // Every high cycle is counted, so a stretched pulse shows up as an extra count.
   always @(negedge clk) begin
      if (wr_en === 1'b1) begin
         if (wr_cnt < 16) begin
            log_addr[wr_cnt] = wr_addr;
            log_data[wr_cnt] = wr_data;
         end
         wr_cnt++;
      end
      if (err === 1'b1) err_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic clocks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bits(input logic [7:0] b, input int n, output logic [7:0] rx);
      rx = '0;
      for (int i = 7; i > 7 - n; i--) begin
         mosi = b[i];
         clocks(2);
         sclk = 1'b1;
         clocks(2);
         rx[i] = miso;
         sclk = 1'b0;
      end
   endtask

   task automatic frame_start;
      ss = 1'b0;
      clocks(4);
   endtask

   task automatic frame_end;
      clocks(4);
      ss = 1'b1;
      clocks(8);
   endtask

   initial begin
      logic [7:0] rx1, rx2, rx3, rx4;
      int         w0, e0;

      clocks(3);
      rst = 1'b0;
      clocks(3);

      // reset asserted in the middle of a byte
      frame_start;
      send_bits(8'hA5, 5, rx1);
      rst = 1'b1;
      clocks(2);
      chk("reset_outputs", {miso, wr_en, err, busy, wr_addr, wr_data}, 32'h0);
      ss = 1'b1;
      clocks(2);
      rst = 1'b0;
      clocks(10);
      chk("reset_no_strobe", wr_cnt, 0);
      chk("reset_no_err", err_cnt, 0);
      chk("idle_busy", busy, 0);
      chk("idle_miso", miso, 0);

      // SCLK activity with SS high must be ignored
      repeat (3) begin
         sclk = 1'b1;
         clocks(2);
         sclk = 1'b0;
         clocks(2);
      end
      chk("ss_high_sclk_no_err", err_cnt, 0);

      // burst of two pairs with echo readback
      w0 = wr_cnt;
      e0 = err_cnt;
      frame_start;
      chk("busy_in_frame", busy, 1);
      send_bits(8'h11, 8, rx1);
      send_bits(8'h02, 8, rx2);
      send_bits(8'h12, 8, rx3);
      send_bits(8'h05, 8, rx4);
      frame_end;
      chk("burst_strobes", wr_cnt - w0, 2);
      chk("burst_addr0", log_addr[w0], 8'h11);
      chk("burst_data0", log_data[w0], 8'h02);
      chk("burst_addr1", log_addr[w0+1], 8'h12);
      chk("burst_data1", log_data[w0+1], 8'h05);
      chk("burst_no_err", err_cnt - e0, 0);
      chk("burst_echo_b1", rx1, 8'h00);
      chk("burst_echo_b2", rx2, 8'h00);
      chk("burst_echo_b3", rx3, 8'h11);
      chk("burst_echo_b4", rx4, 8'h02);
      chk("burst_busy_low", busy, 0);
      chk("burst_hold_addr", wr_addr, 8'h12);
      chk("burst_hold_data", wr_data, 8'h05);

      // single pair; first echoed byte is the last accepted one
      w0 = wr_cnt;
      e0 = err_cnt;
      frame_start;
      send_bits(8'h13, 8, rx1);
      send_bits(8'h08, 8, rx2);
      frame_end;
      chk("single_strobes", wr_cnt - w0, 1);
      chk("single_addr", log_addr[w0], 8'h13);
      chk("single_data", log_data[w0], 8'h08);
      chk("single_no_err", err_cnt - e0, 0);
      chk("single_echo_b1", rx1, 8'h05);

      // odd-length frame, then a good pair
      w0 = wr_cnt;
      e0 = err_cnt;
      frame_start;
      send_bits(8'h13, 8, rx1);
      frame_end;
      chk("odd_no_strobe", wr_cnt - w0, 0);
      chk("odd_err", err_cnt - e0, 1);
      w0 = wr_cnt;
      e0 = err_cnt;
      frame_start;
      send_bits(8'h14, 8, rx1);
      send_bits(8'h09, 8, rx2);
      frame_end;
      chk("after_odd_strobes", wr_cnt - w0, 1);
      chk("after_odd_addr", log_addr[w0], 8'h14);
      chk("after_odd_data", log_data[w0], 8'h09);
      chk("after_odd_no_err", err_cnt - e0, 0);

      // partial byte, then a good pair
      w0 = wr_cnt;
      e0 = err_cnt;
      frame_start;
      send_bits(8'hFF, 5, rx1);
      frame_end;
      chk("partial_no_strobe", wr_cnt - w0, 0);
      chk("partial_err", err_cnt - e0, 1);
      w0 = wr_cnt;
      e0 = err_cnt;
      frame_start;
      send_bits(8'h3C, 8, rx1);
      send_bits(8'hA5, 8, rx2);
      frame_end;
      chk("after_partial_strobes", wr_cnt - w0, 1);
      chk("after_partial_addr", log_addr[w0], 8'h3C);
      chk("after_partial_data", log_data[w0], 8'hA5);
      chk("after_partial_no_err", err_cnt - e0, 0);

      // pair timeout with SS held low, then a pair in the same frame
      w0 = wr_cnt;
      e0 = err_cnt;
      frame_start;
      send_bits(8'h20, 8, rx1);
      clocks(TIMEOUT - 10);
      chk("timeout_not_early", err_cnt - e0, 0);
      clocks(30);
      chk("timeout_err", err_cnt - e0, 1);
      chk("timeout_no_strobe", wr_cnt - w0, 0);
      send_bits(8'h21, 8, rx1);
      send_bits(8'h07, 8, rx2);
      frame_end;
      chk("after_timeout_strobes", wr_cnt - w0, 1);
      chk("after_timeout_addr", log_addr[w0], 8'h21);
      chk("after_timeout_data", log_data[w0], 8'h07);
      chk("after_timeout_err_total", err_cnt - e0, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
